regfile: RTL and testbench
==========================

# regfile

Integer register file for the 5-stage RV32I pipeline. Sits in the decode stage and accepts the single write port driven by the writeback stage (rd_write_w / rd_w / rd_data_w). Provides two combinational read ports with write-through bypass, plus the decode→execute pipeline register for both operands and their indices, with stall, flush and in-stall refresh.

## Interface
Parameters:
- XLEN, 32, register data width
- NREGS, 32, number of architectural registers (x0 hardwired to zero)

Ports:
- clk  input  1  clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- rd_write_w  input  1  write enable from writeback
- rd_w  input  5  write index from writeback
- rd_data_w  input  XLEN  write data from writeback
- rs1_d  input  5  read index 1 (decode)
- rs2_d  input  5  read index 2 (decode)
- rs1_data_d  output  XLEN  combinational read data 1 (bypassed)
- rs2_data_d  output  XLEN  combinational read data 2 (bypassed)
- stall_e  input  1  hold the execute-side operand register
- flush_e  input  1  clear the execute-side operand register (bubble)
- rs1_e  output  5  registered rs1 index for execute/forwarding
- rs2_e  output  5  registered rs2 index
- rs1_data_e  output  XLEN  registered operand 1
- rs2_data_e  output  XLEN  registered operand 2

## Operation
- Storage: x1..x31, XLEN bits each; x0 not stored, always reads 0.
- Write: at posedge clk, if rd_write_w=1 and rd_w≠0, regs[rd_w] ← rd_data_w. Writes to x0 are dropped.
- Read port n (n=1,2), combinational:
  - rsn_d=0 → 0
  - else rd_write_w=1 and rd_w=rsn_d → rd_data_w (write-through bypass; same-cycle write visible)
  - else regs[rsn_d]
- Execute operand register, at posedge clk, priority order:
  1. flush_e=1 → rs1_e, rs2_e, rs1_data_e, rs2_data_e ← 0 (flush beats stall)
  2. stall_e=0 → rsn_e ← rsn_d, rsn_data_e ← rsn_data_d
  3. stall_e=1 → indices hold; for each n, if rd_write_w=1, rd_w≠0, rd_w=rsn_e then rsn_data_e ← rd_data_w (refresh), else hold
- Refresh applies independently to both operands; both refresh when rs1_e=rs2_e=rd_w.
- No internal state machine beyond storage and the operand register; all hazard detection lives outside this block.

## Timing
- Reset (rst_n=0, asynchronous): all x1..x31 ← 0; rs1_e, rs2_e, rs1_data_e, rs2_data_e ← 0. rs1_data_d / rs2_data_d follow combinational rules (0 for all indices unless bypass active).
- Release of rst_n is synchronous to the next posedge; first write possible on the first posedge with rst_n=1.
- Write latency: 1 cycle to storage; 0 cycles to rsn_data_d via bypass.
- Decode→execute latency: 1 cycle (rsn_data_d sampled at posedge into rsn_data_e).
- Simultaneous write and read of the same index in the same cycle: read returns the new data, both combinationally and in the value captured into the execute register.
- rd_w=0 with rd_write_w=1: no storage change, no bypass, no refresh.
- Reset asserted mid-stall or mid-write: the in-flight write is lost; every register returns to 0.

## Test plan
- Reset: load x5=0xDEADBEEF, assert rst_n=0 mid-cycle → x5 reads 0 immediately after, rs1_data_e=0 asynchronously.
- Write/read: write x1=0x12345678, next cycle rs1_d=1, rs2_d=1 → rs1_data_d=rs2_data_d=0x12345678; one posedge later rs1_data_e=0x12345678, rs1_e=1.
- x0: rd_write_w=1, rd_w=0, rd_data_w=0xFFFFFFFF; rs1_d=0 → rs1_data_d=0 same cycle and every later cycle.
- Bypass: x3=0x11 stored; same cycle rd_w=3, rd_data_w=0x22, rs2_d=3 → rs2_data_d=0x22; after posedge rs2_data_e=0x22, regs[3]=0x22.
- Stall refresh: rs1_e=7 holding 0xAA, stall_e=1, write x7=0xBB → after posedge rs1_e=7, rs1_data_e=0xBB; rs2_e=4 unchanged.
- Flush over stall: stall_e=1, flush_e=1, rs1_d=2 with x2=0x55 → after posedge rs1_e=0, rs1_data_e=0, rs2_data_e=0.

Source files
------------

// File: rtl/regfile.sv
// RV32I integer register file with write-through read ports
// and the decode-to-execute operand register.
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_write_w,
    input  logic [4:0]      rd_w,
    input  logic [XLEN-1:0] rd_data_w,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    output logic [XLEN-1:0] rs1_data_d,
    output logic [XLEN-1:0] rs2_data_d,
    input  logic            stall_e,
    input  logic            flush_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [XLEN-1:0] rs1_data_e,
    output logic [XLEN-1:0] rs2_data_e
);

    logic [XLEN-1:0] r_regs [1:NREGS-1];
    logic [4:0]      r_rs1_e;
    logic [4:0]      r_rs2_e;
    logic [XLEN-1:0] r_rs1_data_e;
    logic [XLEN-1:0] r_rs2_data_e;
    logic            w_wr_en;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_ref1;
    logic            w_ref2;

    assign w_wr_en = rd_write_w && (rd_w != 5'd0);

    // x0 reads zero; a same-cycle write to the index wins over storage
    always_comb begin
        w_rs1_data = '0;
        if (rs1_d != 5'd0) begin
            if (w_wr_en && rd_w == rs1_d) w_rs1_data = rd_data_w;
            else                          w_rs1_data = r_regs[rs1_d];
        end
    end

    always_comb begin
        w_rs2_data = '0;
        if (rs2_d != 5'd0) begin
            if (w_wr_en && rd_w == rs2_d) w_rs2_data = rd_data_w;
            else                          w_rs2_data = r_regs[rs2_d];
        end
    end

    assign w_ref1 = w_wr_en && (rd_w == r_rs1_e);
    assign w_ref2 = w_wr_en && (rd_w == r_rs2_e);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[rd_w] <= rd_data_w;
        end
    end

    // Flush beats stall; a stalled operand still picks up a late writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1_e      <= '0;
            r_rs2_e      <= '0;
            r_rs1_data_e <= '0;
            r_rs2_data_e <= '0;
        end else if (flush_e) begin
            r_rs1_e      <= '0;
            r_rs2_e      <= '0;
            r_rs1_data_e <= '0;
            r_rs2_data_e <= '0;
        end else if (!stall_e) begin
            r_rs1_e      <= rs1_d;
            r_rs2_e      <= rs2_d;
            r_rs1_data_e <= w_rs1_data;
            r_rs2_data_e <= w_rs2_data;
        end else begin
            if (w_ref1) r_rs1_data_e <= rd_data_w;
            if (w_ref2) r_rs2_data_e <= rd_data_w;
        end
    end

    assign rs1_data_d = w_rs1_data;
    assign rs2_data_d = w_rs2_data;
    assign rs1_e      = r_rs1_e;
    assign rs2_e      = r_rs2_e;
    assign rs1_data_e = r_rs1_data_e;
    assign rs2_data_e = r_rs2_data_e;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, x0, bypass,
// stall refresh, flush priority and asynchronous reset.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic        rd_write_w;
    logic [4:0]  rd_w;
    logic [31:0] rd_data_w;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [31:0] rs1_data_d;
    logic [31:0] rs2_data_d;
    logic        stall_e;
    logic        flush_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [31:0] rs1_data_e;
    logic [31:0] rs2_data_e;

    int n_tests = 0;
    int n_fail  = 0;

    regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_write_w (rd_write_w),
        .rd_w       (rd_w),
        .rd_data_w  (rd_data_w),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rs1_data_d (rs1_data_d),
        .rs2_data_d (rs2_data_d),
        .stall_e    (stall_e),
        .flush_e    (flush_e),
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rs1_data_e (rs1_data_e),
        .rs2_data_e (rs2_data_e)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] val);
        rd_write_w = 1'b1;
        rd_w       = idx;
        rd_data_w  = val;
        step();
        rd_write_w = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rd_write_w = 1'b0; rd_w = '0; rd_data_w = '0;
        rs1_d = 5'd5; rs2_d = 5'd0; stall_e = 1'b0; flush_e = 1'b0;
        #3;
        check("rst_rs1_data_d", rs1_data_d, 32'h0);
        check("rst_rs1_e", {27'd0, rs1_e}, 32'h0);
        check("rst_rs1_data_e", rs1_data_e, 32'h0);
        check("rst_rs2_data_e", rs2_data_e, 32'h0);
        #9 rst_n = 1'b1;
        step();

        // write x1 then read on both ports
        wr(5'd1, 32'h12345678);
        rs1_d = 5'd1; rs2_d = 5'd1;
        #1;
        check("rd1_x1", rs1_data_d, 32'h12345678);
        check("rd2_x1", rs2_data_d, 32'h12345678);
        step();
        check("e1_x1", rs1_data_e, 32'h12345678);
        check("e1_idx", {27'd0, rs1_e}, 32'd1);
        check("e2_x1", rs2_data_e, 32'h12345678);

        // x0 write dropped, no bypass
        rd_write_w = 1'b1; rd_w = 5'd0; rd_data_w = 32'hFFFFFFFF;
        rs1_d = 5'd0;
        #1;
        check("x0_same", rs1_data_d, 32'h0);
        step();
        check("x0_e", rs1_data_e, 32'h0);
        check("x0_later", rs1_data_d, 32'h0);
        rd_write_w = 1'b0;

        // bypass on same-cycle write
        wr(5'd3, 32'h11);
        rd_write_w = 1'b1; rd_w = 5'd3; rd_data_w = 32'h22;
        rs1_d = 5'd1; rs2_d = 5'd3;
        #1;
        check("byp_d", rs2_data_d, 32'h22);
        step();
        rd_write_w = 1'b0;
        #1;
        check("byp_e", rs2_data_e, 32'h22);
        check("byp_store", rs2_data_d, 32'h22);
        check("byp_rs1_e", rs1_data_e, 32'h12345678);

        // stall refresh on rs1 only
        wr(5'd7, 32'hAA);
        wr(5'd4, 32'h44);
        rs1_d = 5'd7; rs2_d = 5'd4;
        step();
        check("ld_rs1_e", rs1_data_e, 32'hAA);
        check("ld_rs2_e", rs2_data_e, 32'h44);
        stall_e = 1'b1; rs1_d = 5'd1; rs2_d = 5'd1;
        wr(5'd7, 32'hBB);
        check("stl_idx1", {27'd0, rs1_e}, 32'd7);
        check("stl_ref1", rs1_data_e, 32'hBB);
        check("stl_idx2", {27'd0, rs2_e}, 32'd4);
        check("stl_hold2", rs2_data_e, 32'h44);
        wr(5'd0, 32'hCC);
        check("stl_x0", rs1_data_e, 32'hBB);
        step();
        check("stl_hold1", rs1_data_e, 32'hBB);

        // both operands refresh from one write
        stall_e = 1'b0; rs1_d = 5'd9; rs2_d = 5'd9;
        step();
        stall_e = 1'b1;
        wr(5'd9, 32'h99);
        check("both_ref1", rs1_data_e, 32'h99);
        check("both_ref2", rs2_data_e, 32'h99);

        // flush wins over stall
        wr(5'd2, 32'h55);
        flush_e = 1'b1; rs1_d = 5'd2;
        step();
        check("fl_rs1_e", {27'd0, rs1_e}, 32'h0);
        check("fl_rs2_e", {27'd0, rs2_e}, 32'h0);
        check("fl_d1", rs1_data_e, 32'h0);
        check("fl_d2", rs2_data_e, 32'h0);
        check("fl_x2", rs1_data_d, 32'h55);
        flush_e = 1'b0; stall_e = 1'b0;

        // asynchronous reset mid-cycle
        wr(5'd5, 32'hDEADBEEF);
        rs1_d = 5'd5; rs2_d = 5'd1;
        step();
        check("pre_rst", rs1_data_e, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        check("arst_x5", rs1_data_d, 32'h0);
        check("arst_x1", rs2_data_d, 32'h0);
        check("arst_e1", rs1_data_e, 32'h0);
        check("arst_idx", {27'd0, rs1_e}, 32'h0);
        #2 rst_n = 1'b1;
        step();
        check("post_rst", rs1_data_e, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
